// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the control-word type that travels
// down the alignment pipe alongside the pixel data.
package vga_timing_pkg;

   localparam int unsigned VGA_H_VISIBLE = 640;
   localparam int unsigned VGA_H_FP      = 16;
   localparam int unsigned VGA_H_SYNC    = 96;
   localparam int unsigned VGA_H_BP      = 48;
   localparam int unsigned VGA_V_VISIBLE = 480;
   localparam int unsigned VGA_V_FP      = 10;
   localparam int unsigned VGA_V_SYNC    = 2;
   localparam int unsigned VGA_V_BP      = 33;

   localparam int unsigned VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int unsigned VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   localparam int unsigned VGA_BYTES_PER_LINE = VGA_H_VISIBLE / 8;
   localparam int unsigned VGA_FB_DEPTH       = VGA_BYTES_PER_LINE * VGA_V_VISIBLE;

   localparam int unsigned CNT_W  = 10;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned RGB_W  = 12;

   // Per-pixel control word: syncs are active-low, first marks pixel (0,0).
   typedef struct packed {
      logic hsync;
      logic vsync;
      logic blank;
      logic first;
   } vid_ctl_t;

   localparam vid_ctl_t CTL_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank: 1'b1, first: 1'b0};

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v raster counters with raw (unregistered) sync/blank decode.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
   parameter int unsigned H_FP      = VGA_H_FP,
   parameter int unsigned H_SYNC    = VGA_H_SYNC,
   parameter int unsigned H_BP      = VGA_H_BP,
   parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
   parameter int unsigned V_FP      = VGA_V_FP,
   parameter int unsigned V_SYNC    = VGA_V_SYNC,
   parameter int unsigned V_BP      = VGA_V_BP
)(
   input  logic             clk,
   input  logic             rst,
   output logic [CNT_W-1:0] h,
   output logic [CNT_W-1:0] v,
   output logic             visible,
   output vid_ctl_t         ctl
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
   localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

   // Raster counters; line wrap and frame wrap land in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h <= '0;
         v <= '0;
      end else if (h == H_LAST) begin
         h <= '0;
         if (v == V_LAST) begin
            v <= '0;
         end else begin
            v <= v + 1'b1;
         end
      end else begin
         h <= h + 1'b1;
      end
   end

   // Decode raw timing flags for the current counter position.
   always_comb begin
      ctl       = CTL_IDLE;
      visible   = (h < H_VIS) && (v < V_VIS);
      ctl.hsync = ~((h >= HS_START) && (h < HS_END));
      ctl.vsync = ~((v >= VS_START) && (v < VS_END));
      ctl.blank = ~visible;
      ctl.first = (h == '0) && (v == '0);
   end

endmodule

// File: rtl/vga_fb_reader.sv
// 1-bpp frame-buffer scan-out: fetches one byte per 8 visible pixels,
// serialises leftmost-first and aligns syncs/blank to the pixel stream.
module vga_fb_reader
   import vga_timing_pkg::*;
#(
   parameter int unsigned      H_VISIBLE  = VGA_H_VISIBLE,
   parameter int unsigned      H_FP       = VGA_H_FP,
   parameter int unsigned      H_SYNC     = VGA_H_SYNC,
   parameter int unsigned      H_BP       = VGA_H_BP,
   parameter int unsigned      V_VISIBLE  = VGA_V_VISIBLE,
   parameter int unsigned      V_FP       = VGA_V_FP,
   parameter int unsigned      V_SYNC     = VGA_V_SYNC,
   parameter int unsigned      V_BP       = VGA_V_BP,
   parameter int unsigned      RD_LATENCY = 1,
   parameter logic [RGB_W-1:0] FG_RGB     = 12'hFFF,
   parameter logic [RGB_W-1:0] BG_RGB     = 12'h000
)(
   input  logic              clock25,
   input  logic              reset,
   output logic [ADDR_W-1:0] rd_add,
   output logic              rd_en,
   input  logic [0:7]        rd_data,
   output logic              hsync,
   output logic              vsync,
   output logic [RGB_W-1:0]  rgb,
   output logic              blank,
   output logic              frame_start
);

   localparam int unsigned LAT = RD_LATENCY + 2;

   logic [CNT_W-1:0]  h;
   logic [CNT_W-1:0]  v;
   logic              visible;
   vid_ctl_t          ctl_raw;

   logic              fetch;
   logic [ADDR_W-1:0] v_wide;
   logic [ADDR_W-1:0] line_base;
   logic [ADDR_W-1:0] col;

   logic [RD_LATENCY-1:0] en_pipe;
   logic                  load;
   vid_ctl_t              ctl_pipe [LAT];

   logic [7:0] data_norm;
   logic [7:0] sr;
   logic       pix_bit;

   vga_timing_gen #(
      .H_VISIBLE (H_VISIBLE),
      .H_FP      (H_FP),
      .H_SYNC    (H_SYNC),
      .H_BP      (H_BP),
      .V_VISIBLE (V_VISIBLE),
      .V_FP      (V_FP),
      .V_SYNC    (V_SYNC),
      .V_BP      (V_BP)
   ) u_timing (
      .clk     (clock25),
      .rst     (reset),
      .h       (h),
      .v       (v),
      .visible (visible),
      .ctl     (ctl_raw)
   );

   // Byte address for the current position: v*80 built from two shifts.
   always_comb begin
      fetch     = visible && (h[2:0] == 3'd0);
      v_wide    = ADDR_W'(v);
      line_base = (v_wide << 6) + (v_wide << 4);
      col       = ADDR_W'(h[CNT_W-1:3]);
   end

   // Issue a read at each 8-pixel boundary; address holds through blanking.
   always_ff @(posedge clock25 or posedge reset) begin
      if (reset) begin
         rd_add <= '0;
         rd_en  <= 1'b0;
      end else begin
         rd_en <= fetch;
         if (fetch) begin
            rd_add <= line_base + col;
         end
      end
   end

   // Delay the read strobe to mark the cycle rd_data is valid.
   always_ff @(posedge clock25 or posedge reset) begin
      if (reset) begin
         en_pipe <= '0;
      end else begin
         en_pipe[0] <= rd_en;
         for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            en_pipe[i] <= en_pipe[i-1];
         end
      end
   end

   // Control pipe keeps syncs/blank/frame marker aligned with the pixel.
   always_ff @(posedge clock25 or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < LAT; i++) begin
            ctl_pipe[i] <= CTL_IDLE;
         end
      end else begin
         ctl_pipe[0] <= ctl_raw;
         for (int unsigned i = 1; i < LAT; i++) begin
            ctl_pipe[i] <= ctl_pipe[i-1];
         end
      end
   end

   // Pixel 0 of a fresh byte bypasses the shifter so the rgb register sees
   // it in the load cycle; the shifter then carries pixels 1..7.
   always_comb begin
      load = en_pipe[RD_LATENCY-1];
      for (int unsigned i = 0; i < 8; i++) begin
         data_norm[i] = rd_data[i];
      end
      pix_bit = load ? data_norm[0] : sr[0];
   end

   // Shift register, leftmost pixel in bit 0.
   always_ff @(posedge clock25 or posedge reset) begin
      if (reset) begin
         sr <= '0;
      end else if (load) begin
         sr <= {1'b0, data_norm[7:1]};
      end else begin
         sr <= {1'b0, sr[7:1]};
      end
   end

   // Registered colour, forced to zero while blanked.
   always_ff @(posedge clock25 or posedge reset) begin
      if (reset) begin
         rgb <= '0;
      end else begin
         rgb <= ctl_pipe[LAT-2].blank ? '0 : (pix_bit ? FG_RGB : BG_RGB);
      end
   end

   assign hsync       = ctl_pipe[LAT-1].hsync;
   assign vsync       = ctl_pipe[LAT-1].vsync;
   assign blank       = ctl_pipe[LAT-1].blank;
   assign frame_start = ctl_pipe[LAT-1].first;

endmodule

// File: tb/tb_vga_fb_reader.sv
// Bench for vga_fb_reader: two shrunken-raster instances (RD_LATENCY 1 and 2)
// checked every cycle against a position-from-cycle-count reference model.
module tb_vga_fb_reader;

   localparam int FB_BYTES = 38400;

   // Instance A: 480 lines so the high-line address arithmetic is exercised.
   localparam int A_HV = 16, A_HF = 1, A_HS = 4, A_HB = 3;
   localparam int A_VV = 480, A_VF = 1, A_VS = 2, A_VB = 2;
   localparam logic [11:0] A_FG = 12'hFFF, A_BG = 12'h000;
   // Instance B: small raster, non-default colours.
   localparam int B_HV = 32, B_HF = 4, B_HS = 8, B_HB = 4;
   localparam int B_VV = 8, B_VF = 1, B_VS = 2, B_VB = 2;
   localparam logic [11:0] B_FG = 12'h5A3, B_BG = 12'h00C;

   localparam int PAT_ZERO = 0, PAT_INDEX = 1, PAT_SINGLE = 2, PAT_RANDOM = 3, PAT_KEEP = 4;

   typedef struct {
      int hv, hf, hs, hb, vv, vf, vs, vb, lat;
      logic [11:0] fg, bg;
   } cfg_t;

   cfg_t cfg [2];

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic armed = 1'b0;
   int   n     = 0;

   logic [7:0] mem [FB_BYTES];

   logic [15:0] a_rd_add, b_rd_add;
   logic        a_rd_en, b_rd_en;
   logic [7:0]  a_q1, b_q1, b_q2;
   logic        a_hsync, a_vsync, a_blank, a_fs;
   logic        b_hsync, b_vsync, b_blank, b_fs;
   logic [11:0] a_rgb, b_rgb;

   int vectors = 0;
   int miscompares = 0;

   int          seen [2];
   int          w_len [2], w_en [2], w_hlow [2], w_vlow [2], w_fg [2];
   logic [15:0] w_max [2];
   int          exp_fg [2];
   logic [15:0] exp_addr [2];

   always #20 clk = ~clk;

   vga_fb_reader #(
      .H_VISIBLE(A_HV), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
      .V_VISIBLE(A_VV), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
      .RD_LATENCY(1), .FG_RGB(A_FG), .BG_RGB(A_BG)
   ) dut_a (
      .clock25(clk), .reset(reset), .rd_add(a_rd_add), .rd_en(a_rd_en),
      .rd_data(a_q1), .hsync(a_hsync), .vsync(a_vsync), .rgb(a_rgb),
      .blank(a_blank), .frame_start(a_fs)
   );

   vga_fb_reader #(
      .H_VISIBLE(B_HV), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
      .V_VISIBLE(B_VV), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
      .RD_LATENCY(2), .FG_RGB(B_FG), .BG_RGB(B_BG)
   ) dut_b (
      .clock25(clk), .reset(reset), .rd_add(b_rd_add), .rd_en(b_rd_en),
      .rd_data(b_q2), .hsync(b_hsync), .vsync(b_vsync), .rgb(b_rgb),
      .blank(b_blank), .frame_start(b_fs)
   );

   // Synchronous RAM read ports: 1 and 2 clocks of latency.
   always @(posedge clk) begin
      a_q1 <= (int'(a_rd_add) < FB_BYTES) ? mem[a_rd_add] : 8'h00;
      b_q1 <= (int'(b_rd_add) < FB_BYTES) ? mem[b_rd_add] : 8'h00;
      b_q2 <= b_q1;
   end

   // Clock edges since reset release.
   always @(posedge clk) n <= reset ? 0 : n + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic string pfx(input int id);
      return (id == 0) ? "A" : "B";
   endfunction

   // Pixel bit at (x,y): MSB of the stored byte is the leftmost pixel.
   function automatic logic pixel(input int x, input int y);
      logic [7:0] b;
      b = mem[y * 80 + x / 8];
      return b[7 - (x % 8)];
   endfunction

   // Expected {hsync, vsync, blank, frame_start, rgb} k edges after release.
   function automatic logic [15:0] model_out(input int id, input int k);
      cfg_t c;
      int t, ht, vt, h, v;
      logic vis, hs, vs, fs;
      logic [11:0] col;
      c = cfg[id];
      t = k - c.lat;
      if (t < 0) return {1'b1, 1'b1, 1'b1, 1'b0, 12'h000};
      ht  = c.hv + c.hf + c.hs + c.hb;
      vt  = c.vv + c.vf + c.vs + c.vb;
      h   = t % ht;
      v   = (t / ht) % vt;
      vis = (h < c.hv) && (v < c.vv);
      hs  = !((h >= c.hv + c.hf) && (h < c.hv + c.hf + c.hs));
      vs  = !((v >= c.vv + c.vf) && (v < c.vv + c.vf + c.vs));
      fs  = (h == 0) && (v == 0);
      col = vis ? (pixel(h, v) ? c.fg : c.bg) : 12'h000;
      return {hs, vs, !vis, fs, col};
   endfunction

   // Expected {rd_en, address} k edges after release (fetch of position k-1).
   function automatic logic [16:0] model_fetch(input int id, input int k);
      cfg_t c;
      int t, ht, vt, h, v;
      c = cfg[id];
      if (k < 1) return '0;
      t  = k - 1;
      ht = c.hv + c.hf + c.hs + c.hb;
      vt = c.vv + c.vf + c.vs + c.vb;
      h  = t % ht;
      v  = (t / ht) % vt;
      if ((h < c.hv) && (v < c.vv) && (h % 8 == 0)) return {1'b1, 16'(v * 80 + h / 8)};
      return '0;
   endfunction

   function automatic int count_fg(input int id);
      int s = 0;
      for (int y = 0; y < cfg[id].vv; y++)
         for (int x = 0; x < cfg[id].hv; x++)
            s += int'(pixel(x, y));
      return s;
   endfunction

   task automatic check_cycle(input int id, input logic hs, input logic vs, input logic bl,
                              input logic fs, input logic [11:0] col, input logic en,
                              input logic [15:0] add);
      logic [15:0] e;
      logic [16:0] f;
      cfg_t c;
      int ht, vt;
      string p;
      c  = cfg[id];
      p  = pfx(id);
      ht = c.hv + c.hf + c.hs + c.hb;
      vt = c.vv + c.vf + c.vs + c.vb;
      e  = model_out(id, n);
      f  = model_fetch(id, n);
      if (f[16]) exp_addr[id] = f[15:0];
      check_eq({p, ".hsync"}, 32'(hs), 32'(e[15]));
      check_eq({p, ".vsync"}, 32'(vs), 32'(e[14]));
      check_eq({p, ".blank"}, 32'(bl), 32'(e[13]));
      check_eq({p, ".frame_start"}, 32'(fs), 32'(e[12]));
      check_eq({p, ".rgb"}, 32'(col), 32'(e[11:0]));
      check_eq({p, ".rd_en"}, 32'(en), 32'(f[16]));
      check_eq({p, ".rd_add"}, 32'(add), 32'(exp_addr[id]));
      // Whole-frame totals between consecutive frame_start pulses.
      if (fs === 1'b1) begin
         if (seen[id] != 0) begin
            check_eq({p, ".frame_len"}, 32'(w_len[id]), 32'(ht * vt));
            check_eq({p, ".reads_per_frame"}, 32'(w_en[id]), 32'(c.vv * c.hv / 8));
            check_eq({p, ".hsync_low_clks"}, 32'(w_hlow[id]), 32'(vt * c.hs));
            check_eq({p, ".vsync_low_clks"}, 32'(w_vlow[id]), 32'(c.vs * ht));
            check_eq({p, ".fg_pixels"}, 32'(w_fg[id]), 32'(exp_fg[id]));
            check_eq({p, ".max_rd_add"}, 32'(w_max[id]), 32'((c.vv - 1) * 80 + c.hv / 8 - 1));
         end
         seen[id] = 1;
         w_len[id] = 0; w_en[id] = 0; w_hlow[id] = 0; w_vlow[id] = 0; w_fg[id] = 0;
         w_max[id] = '0;
      end
      w_len[id]++;
      if (en === 1'b1) begin
         w_en[id]++;
         if (add > w_max[id]) w_max[id] = add;
      end
      if (hs === 1'b0) w_hlow[id]++;
      if (vs === 1'b0) w_vlow[id]++;
      if ((bl === 1'b0) && (col === c.fg)) w_fg[id]++;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            for (int i = 0; i < 2; i++) begin
               seen[i] = 0;
               exp_addr[i] = '0;
            end
         end else if (armed) begin
            check_cycle(0, a_hsync, a_vsync, a_blank, a_fs, a_rgb, a_rd_en, a_rd_add);
            check_cycle(1, b_hsync, b_vsync, b_blank, b_fs, b_rgb, b_rd_en, b_rd_add);
         end
      end
   end

   // Raise reset mid-cycle, confirm async clear, reload memory, hold 3 clocks.
   task automatic do_reset(input int pat);
      @(negedge clk);
      #5 reset = 1'b1;
      #1;
      check_eq("A.rst_hsync", 32'(a_hsync), 32'd1);
      check_eq("A.rst_vsync", 32'(a_vsync), 32'd1);
      check_eq("A.rst_blank", 32'(a_blank), 32'd1);
      check_eq("A.rst_frame_start", 32'(a_fs), 32'd0);
      check_eq("A.rst_rgb", 32'(a_rgb), 32'd0);
      check_eq("A.rst_rd_en", 32'(a_rd_en), 32'd0);
      check_eq("A.rst_rd_add", 32'(a_rd_add), 32'd0);
      check_eq("B.rst_hsync", 32'(b_hsync), 32'd1);
      check_eq("B.rst_vsync", 32'(b_vsync), 32'd1);
      check_eq("B.rst_blank", 32'(b_blank), 32'd1);
      check_eq("B.rst_frame_start", 32'(b_fs), 32'd0);
      check_eq("B.rst_rgb", 32'(b_rgb), 32'd0);
      check_eq("B.rst_rd_en", 32'(b_rd_en), 32'd0);
      check_eq("B.rst_rd_add", 32'(b_rd_add), 32'd0);
      armed = 1'b1;
      if (pat != PAT_KEEP) begin
         for (int a = 0; a < FB_BYTES; a++) begin
            case (pat)
               PAT_ZERO:   mem[a] = 8'h00;
               PAT_INDEX:  mem[a] = 8'(a);
               PAT_SINGLE: mem[a] = (a == 0) ? 8'b1000_0000 : 8'h00;
               default:    mem[a] = 8'($urandom);
            endcase
         end
      end
      exp_fg[0] = count_fg(0);
      exp_fg[1] = count_fg(1);
      repeat (3) @(negedge clk);
      #5 reset = 1'b0;
   endtask

   initial begin
      cfg[0] = '{hv: A_HV, hf: A_HF, hs: A_HS, hb: A_HB, vv: A_VV, vf: A_VF, vs: A_VS, vb: A_VB,
                 lat: 3, fg: A_FG, bg: A_BG};
      cfg[1] = '{hv: B_HV, hf: B_HF, hs: B_HS, hb: B_HB, vv: B_VV, vf: B_VF, vs: B_VS, vb: B_VB,
                 lat: 4, fg: B_FG, bg: B_BG};
      for (int i = 0; i < 2; i++) begin
         seen[i] = 0;
         exp_addr[i] = '0;
      end

      do_reset(PAT_ZERO);
      repeat (12000) @(negedge clk);
      do_reset(PAT_INDEX);
      repeat (12000) @(negedge clk);
      do_reset(PAT_SINGLE);
      repeat (12000) @(negedge clk);
      do_reset(PAT_RANDOM);
      repeat (5000 + int'($urandom_range(0, 999))) @(negedge clk);
      do_reset(PAT_KEEP);
      repeat (12000) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
